// File: rtl/bcd.sv
`timescale 1ns/1ps
// Combinational 13-bit binary to 4-digit BCD converter (double-dabble).
// Any 13-bit value is at most 8191, so the thousands digit never overflows.
module bcd (
  input  logic [12:0] bin,
  output logic [3:0]  thousands,
  output logic [3:0]  hundreds,
  output logic [3:0]  tens,
  output logic [3:0]  ones
);

  // BCD digits occupy [28:13]; the binary is shifted up out of [12:0]
  logic [28:0] s;

  always_comb begin
    s = {16'd0, bin};
    for (int i = 0; i < 13; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (s[13+4*k +: 4] >= 4'd5) s[13+4*k +: 4] = s[13+4*k +: 4] + 4'd3;
      end
      s = s << 1;
    end
    thousands = s[28:25];
    hundreds  = s[24:21];
    tens      = s[20:17];
    ones      = s[16:13];
  end

endmodule

// File: rtl/lcd_lab3.sv
`timescale 1ns/1ps
// HD44780 16x2 LCD driver, 8-bit write-only: power-up wait, 4 init commands, then an endless
// refresh of two lines showing two BCD values in a layout picked by Choice.
module lcd_lab3 #(
  parameter int unsigned POWERUP_CYCLES    = 1_000_000,
  parameter int unsigned EN_PULSE_CYCLES   = 25,
  parameter int unsigned CMD_WAIT_CYCLES   = 2_500,
  parameter int unsigned CLEAR_WAIT_CYCLES = 100_000
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic [15:0] Choice,
  input  logic [3:0]  ThousandsBin1,
  input  logic [3:0]  HundredsBin1,
  input  logic [3:0]  TensBin1,
  input  logic [3:0]  OnesBin1,
  input  logic [3:0]  ThousandsBin2,
  input  logic [3:0]  HundredsBin2,
  input  logic [3:0]  TensBin2,
  input  logic [3:0]  OnesBin2,
  output logic        GPIO_0,
  output logic        GPIO_1,
  output logic        LCD_ON,
  output logic        LCD_BLON,
  output logic        LCD_RW,
  output logic        LCD_EN,
  output logic        LCD_RS,
  inout  wire  [7:0]  LCD_DATA
);

  typedef enum logic [2:0] {StPwrWait, StSetup, StPulse, StHold, StWait} state_e;

  state_e      state_q;
  logic [31:0] cnt_q;
  logic        in_frame_q;
  logic [5:0]  idx_q;
  logic        en_q, rs_q, init_done_q, frame_tgl_q;
  logic [7:0]  data_q;
  logic [15:0] choice_q, d1_q, d2_q;

  logic        wrap, nxt_frame, nxt_rs;
  logic [5:0]  nxt_idx;
  logic [7:0]  nxt_byte;
  logic [31:0] wait_last;

  function automatic logic [7:0] dig_ascii(input logic [3:0] d);
    return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h2D;
  endfunction

  function automatic logic [7:0] char_at(input logic line2, input logic [3:0] col,
                                         input logic [15:0] choice, input logic [15:0] d1,
                                         input logic [15:0] d2);
    logic [63:0] pre;
    logic [15:0] dv;
    logic        blank;
    int          c;
    c     = int'(col);
    pre   = "        ";
    dv    = d1;
    blank = 1'b0;
    case (choice)
      16'h0000: begin pre = "RESULT: "; blank = line2; end
      16'h0001: begin pre = "INPUT:  "; blank = line2; end
      16'h0002: begin
        pre = line2 ? "B:      " : "A:      ";
        dv  = line2 ? d2 : d1;
      end
      default:  blank = 1'b1;
    endcase
    if (blank || c >= 12) return 8'h20;
    if (c < 8) return pre[8*(7-c) +: 8];
    return dig_ascii(dv[4*(11-c) +: 4]);
  endfunction

  // Position of the next byte; PWR_WAIT launches the byte at the current (reset) position.
  always_comb begin
    wrap = in_frame_q ? (idx_q == 6'd33) : (idx_q == 6'd3);
    if (state_q == StPwrWait) begin
      nxt_frame = in_frame_q;
      nxt_idx   = idx_q;
    end else if (wrap) begin
      nxt_frame = 1'b1;
      nxt_idx   = 6'd0;
    end else begin
      nxt_frame = in_frame_q;
      nxt_idx   = idx_q + 6'd1;
    end

    nxt_rs   = 1'b0;
    nxt_byte = 8'h20;
    if (!nxt_frame) begin
      case (nxt_idx[1:0])
        2'd0:    nxt_byte = 8'h38;
        2'd1:    nxt_byte = 8'h0C;
        2'd2:    nxt_byte = 8'h01;
        default: nxt_byte = 8'h06;
      endcase
    end else if (nxt_idx == 6'd0) begin
      nxt_byte = 8'h80;
    end else if (nxt_idx <= 6'd16) begin
      nxt_rs   = 1'b1;
      nxt_byte = char_at(1'b0, nxt_idx[3:0] - 4'd1, choice_q, d1_q, d2_q);
    end else if (nxt_idx == 6'd17) begin
      nxt_byte = 8'hC0;
    end else begin
      nxt_rs   = 1'b1;
      nxt_byte = char_at(1'b1, nxt_idx[3:0] - 4'd2, choice_q, d1_q, d2_q);
    end

    wait_last = (!rs_q && data_q == 8'h01) ? (CLEAR_WAIT_CYCLES - 32'd1)
                                           : (CMD_WAIT_CYCLES - 32'd1);
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= StPwrWait;
      cnt_q       <= '0;
      in_frame_q  <= 1'b0;
      idx_q       <= '0;
      en_q        <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      init_done_q <= 1'b0;
      frame_tgl_q <= 1'b0;
      choice_q    <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
    end else begin
      case (state_q)
        StPwrWait, StWait: begin
          if (cnt_q == ((state_q == StPwrWait) ? (POWERUP_CYCLES - 32'd1) : wait_last)) begin
            cnt_q      <= '0;
            state_q    <= StSetup;
            rs_q       <= nxt_rs;
            data_q     <= nxt_byte;
            in_frame_q <= nxt_frame;
            idx_q      <= nxt_idx;
            // Snapshot inputs once per frame so a frame never mixes two layouts
            if (nxt_frame && nxt_idx == 6'd0) begin
              choice_q <= Choice;
              d1_q     <= {ThousandsBin1, HundredsBin1, TensBin1, OnesBin1};
              d2_q     <= {ThousandsBin2, HundredsBin2, TensBin2, OnesBin2};
            end
            if (state_q == StWait && wrap && !in_frame_q) init_done_q <= 1'b1;
            if (state_q == StWait && wrap && in_frame_q)  frame_tgl_q <= ~frame_tgl_q;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        StSetup: begin
          en_q    <= 1'b1;
          cnt_q   <= '0;
          state_q <= StPulse;
        end
        StPulse: begin
          if (cnt_q == EN_PULSE_CYCLES - 32'd1) begin
            en_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= StHold;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        StHold: begin
          cnt_q   <= '0;
          state_q <= StWait;
        end
        default: state_q <= StPwrWait;
      endcase
    end
  end

  assign GPIO_0   = init_done_q;
  assign GPIO_1   = frame_tgl_q;
  assign LCD_ON   = 1'b1;
  assign LCD_BLON = 1'b1;
  assign LCD_RW   = 1'b0;
  assign LCD_EN   = en_q;
  assign LCD_RS   = rs_q;
  assign LCD_DATA = data_q;

endmodule

// File: tb/tb_lcd_lab3.sv
`timescale 1ns/1ps
// Scoreboard bench for lcd_lab3: the driver queues expected LCD bytes, the monitor pops one
// per EN strobe and also checks strobe width, byte spacing and the GPIO flags.
module tb_lcd_lab3;

  localparam int unsigned PWR  = 20;
  localparam int unsigned ENP  = 2;
  localparam int unsigned CMDW = 4;
  localparam int unsigned CLRW = 8;

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
    logic       g0;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] choice;
  logic [15:0] v1, v2;
  logic        gpio0, gpio1, lcd_on, lcd_blon, lcd_rw, lcd_en, lcd_rs;
  wire  [7:0]  lcd_data;

  logic [12:0] bcd_in;
  logic [3:0]  bcd_th, bcd_hu, bcd_te, bcd_on;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   frames_seen = 0;
  int   rises_seen  = 0;

  always #5 clk = ~clk;

  lcd_lab3 #(
    .POWERUP_CYCLES   (PWR),
    .EN_PULSE_CYCLES  (ENP),
    .CMD_WAIT_CYCLES  (CMDW),
    .CLEAR_WAIT_CYCLES(CLRW)
  ) dut (
    .CLOCK_50     (clk),
    .RESET_N      (rst_n),
    .Choice       (choice),
    .ThousandsBin1(v1[15:12]),
    .HundredsBin1 (v1[11:8]),
    .TensBin1     (v1[7:4]),
    .OnesBin1     (v1[3:0]),
    .ThousandsBin2(v2[15:12]),
    .HundredsBin2 (v2[11:8]),
    .TensBin2     (v2[7:4]),
    .OnesBin2     (v2[3:0]),
    .GPIO_0       (gpio0),
    .GPIO_1       (gpio1),
    .LCD_ON       (lcd_on),
    .LCD_BLON     (lcd_blon),
    .LCD_RW       (lcd_rw),
    .LCD_EN       (lcd_en),
    .LCD_RS       (lcd_rs),
    .LCD_DATA     (lcd_data)
  );

  bcd u_bcd (
    .bin      (bcd_in),
    .thousands(bcd_th),
    .hundreds (bcd_hu),
    .tens     (bcd_te),
    .ones     (bcd_on)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  function automatic logic [7:0] asc(input logic [3:0] d);
    return (d < 4'd10) ? {4'h3, d} : 8'h2D;
  endfunction

  task automatic push_init();
    exp_q.push_back('{rs: 1'b0, data: 8'h38, g0: 1'b0});
    exp_q.push_back('{rs: 1'b0, data: 8'h0C, g0: 1'b0});
    exp_q.push_back('{rs: 1'b0, data: 8'h01, g0: 1'b0});
    exp_q.push_back('{rs: 1'b0, data: 8'h06, g0: 1'b0});
  endtask

  task automatic push_frame(input logic [15:0] ch, input logic [15:0] a, input logic [15:0] b);
    logic [7:0]  ln [2][16];
    logic [63:0] p1, p2;
    logic        h1, h2;
    h1 = 1'b0; h2 = 1'b0; p1 = '0; p2 = '0;
    case (ch)
      16'h0000: begin p1 = "RESULT: "; h1 = 1'b1; end
      16'h0001: begin p1 = "INPUT:  "; h1 = 1'b1; end
      16'h0002: begin p1 = "A:      "; p2 = "B:      "; h1 = 1'b1; h2 = 1'b1; end
      default: ;
    endcase
    for (int l = 0; l < 2; l++) for (int c = 0; c < 16; c++) ln[l][c] = 8'h20;
    if (h1) begin
      for (int c = 0; c < 8; c++) ln[0][c] = p1[63-8*c -: 8];
      for (int k = 0; k < 4; k++) ln[0][8+k] = asc(a[15-4*k -: 4]);
    end
    if (h2) begin
      for (int c = 0; c < 8; c++) ln[1][c] = p2[63-8*c -: 8];
      for (int k = 0; k < 4; k++) ln[1][8+k] = asc(b[15-4*k -: 4]);
    end
    exp_q.push_back('{rs: 1'b0, data: 8'h80, g0: 1'b1});
    for (int c = 0; c < 16; c++) exp_q.push_back('{rs: 1'b1, data: ln[0][c], g0: 1'b1});
    exp_q.push_back('{rs: 1'b0, data: 8'hC0, g0: 1'b1});
    for (int c = 0; c < 16; c++) exp_q.push_back('{rs: 1'b1, data: ln[1][c], g0: 1'b1});
  endtask

  task automatic check_reset_outputs();
    chk("rst_en",   {31'd0, lcd_en},   0);
    chk("rst_rs",   {31'd0, lcd_rs},   0);
    chk("rst_data", {24'd0, lcd_data}, 0);
    chk("rst_gpio0", {31'd0, gpio0},   0);
    chk("rst_gpio1", {31'd0, gpio1},   0);
    chk("rst_on_blon_rw", {29'd0, lcd_on, lcd_blon, lcd_rw}, 32'b110);
  endtask

  task automatic wait_frames(input int n);
    for (int i = 0; i < 5000 && frames_seen < n; i++) @(posedge clk);
    chk("frame_reached", (frames_seen >= n) ? 32'd1 : 32'd0, 1);
  endtask

  task automatic wait_rises(input int n);
    for (int i = 0; i < 2000 && rises_seen < n; i++) @(posedge clk);
    chk("strobe_reached", (rises_seen >= n) ? 32'd1 : 32'd0, 1);
  endtask

  // Monitor
  initial begin
    logic        en_prev, have_last, last_clear;
    logic [8:0]  cap;
    int          cyc, rel_cnt, last_rise, high, n80;
    exp_t        e;
    en_prev = 1'b0; have_last = 1'b0; last_clear = 1'b0; cap = '0;
    cyc = 0; rel_cnt = 0; last_rise = 0; high = 0; n80 = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        en_prev = 1'b0; have_last = 1'b0; rel_cnt = 0; n80 = 0; cyc = 0;
      end else begin
        cyc++;
        rel_cnt++;
        if (lcd_en && !en_prev) begin
          cap = {lcd_rs, lcd_data};
          rises_seen++;
          if (!have_last) chk("powerup_delay", rel_cnt, PWR + 1);
          else chk("byte_spacing", cyc - last_rise, last_clear ? CLRW + 4 : CMDW + 4);
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_byte: got %0h, expected no strobe (t=%0t)", cap, $time);
          end else begin
            e = exp_q.pop_front();
            chk("byte", {23'd0, cap}, {23'd0, e.rs, e.data});
            chk("gpio0", {31'd0, gpio0}, {31'd0, e.g0});
          end
          if (cap == 9'h080) begin
            chk("gpio1", {31'd0, gpio1}, n80 % 2);
            n80++;
            frames_seen++;
          end
          last_rise  = cyc;
          last_clear = (cap == 9'h001);
          have_last  = 1'b1;
          high       = 1;
        end else if (lcd_en) begin
          high++;
        end else if (en_prev) begin
          chk("en_width", high, ENP);
          chk("hold_data", {23'd0, lcd_rs, lcd_data}, {23'd0, cap});
        end
        en_prev = lcd_en;
      end
    end
  end

  // Driver
  initial begin
    rst_n  = 1'b0;
    choice = 16'h0002;
    v1     = 16'h0427;
    v2     = 16'h9999;
    bcd_in = '0;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs();
    push_init();
    push_frame(16'h0002, 16'h0427, 16'h9999);
    @(negedge clk);
    #1 rst_n = 1'b1;

    wait_frames(1);
    choice = 16'hFFFF;
    push_frame(16'hFFFF, v1, v2);

    wait_frames(2);
    choice = 16'h0000;
    v1     = 16'h123A;
    push_frame(16'h0000, 16'h123A, v2);

    // Change layout while line 1 of frame 3 is being written
    wait_frames(3);
    wait_rises(rises_seen + 5);
    choice = 16'h0001;
    push_frame(16'h0001, 16'h123A, v2);

    // Reset in the middle of an EN-high pulse
    wait_frames(4);
    wait_rises(rises_seen + 3);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (lcd_en) break;
    end
    chk("en_seen_before_reset", {31'd0, lcd_en}, 1);
    rst_n = 1'b0;
    exp_q.delete();
    #1 chk("rst_en_async", {31'd0, lcd_en}, 0);
    repeat (3) @(negedge clk);
    #1 check_reset_outputs();
    push_init();
    push_frame(16'h0001, 16'h123A, v2);
    @(negedge clk);
    #1 rst_n = 1'b1;

    wait_frames(5);
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);

    bcd_in = 13'd8191; #1 chk("bcd_8191", {bcd_th, bcd_hu, bcd_te, bcd_on}, 16'h8191);
    bcd_in = 13'd0;    #1 chk("bcd_0",    {bcd_th, bcd_hu, bcd_te, bcd_on}, 16'h0000);
    bcd_in = 13'd1234; #1 chk("bcd_1234", {bcd_th, bcd_hu, bcd_te, bcd_on}, 16'h1234);
    bcd_in = 13'd4095; #1 chk("bcd_4095", {bcd_th, bcd_hu, bcd_te, bcd_on}, 16'h4095);
    bcd_in = 13'd999;  #1 chk("bcd_999",  {bcd_th, bcd_hu, bcd_te, bcd_on}, 16'h0999);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
